// File: rtl/prefix_add_pkg.sv
// Shared types and helpers for the shared prefix-adder arbiter.
// Holds default sizes, the lock FSM encoding and the round-robin pick function.
package prefix_add_pkg;

  localparam int unsigned DefaultW    = 8;
  localparam int unsigned DefaultNreq = 4;
  localparam int unsigned MaxNreq     = 8;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  // Returns {found, idx[2:0]}: first set bit of eligible at or after (ptr+1) mod nreq.
  function automatic logic [3:0] rr_pick(input logic [MaxNreq-1:0] eligible,
                                         input int unsigned        nreq,
                                         input logic [2:0]         ptr);
    logic [3:0]  res;
    logic        found;
    int unsigned idx;
    logic [2:0]  idx3;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxNreq; k++) begin
      idx  = (32'(ptr) + k) % nreq;
      idx3 = idx[2:0];
      if (k <= nreq && !found && eligible[idx3]) begin
        found = 1'b1;
        res   = {1'b1, idx3};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// Combinational W-bit Kogge-Stone adder with carry-in and carry-out.
// Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
module prefix_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned Levels = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0] p0;
  logic [W-1:0] g0;
  logic [W-1:0] g_final;
  logic [W-1:0] carry;

  always_comb begin
    p0    = a ^ b;
    g0    = a & b;
    g0[0] = (a[0] & b[0]) | (p0[0] & cin);
  end

  genvar l, i;
  generate
    for (l = 0; l < Levels; l++) begin : g_level
      localparam int unsigned Dist = 1 << l;
      logic [W-1:0] gi, pi, go, po;
      if (l == 0) begin : g_first
        assign gi = g0;
        assign pi = p0;
      end else begin : g_chain
        assign gi = g_level[l-1].go;
        assign pi = g_level[l-1].po;
      end
      for (i = 0; i < W; i++) begin : g_bit
        if (i >= Dist) begin : g_merge
          assign go[i] = gi[i] | (pi[i] & gi[i-Dist]);
          assign po[i] = pi[i] & pi[i-Dist];
        end else begin : g_pass
          assign go[i] = gi[i];
          assign po[i] = pi[i];
        end
      end
    end
  endgenerate

  assign g_final = g_level[Levels-1].go;

  logic unused_po;
  assign unused_po = ^g_level[Levels-1].po;

  always_comb begin
    carry = {g_final[W-2:0], cin};
  end

  assign sum  = p0 ^ carry;
  assign cout = g_final[W-1];

endmodule

// File: rtl/prefix_add_arbiter.sv
// Round-robin arbiter sharing one prefix adder among NREQ requesters, with grant
// locking for multi-limb sums and a one-deep registered response stage.
module prefix_add_arbiter
  import prefix_add_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = DefaultW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ-1:0]          req_chain,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_sum,
  output logic                     rsp_cout,
  output logic [$clog2(NREQ)-1:0]  rsp_id
);

  localparam int unsigned IdW = $clog2(NREQ);

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic           carry_q, carry_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;

  logic [MaxNreq-1:0] eligible;
  logic [3:0]         pick;
  logic [2:0]         ptr_ext;
  logic               grant_valid;
  logic [IdW-1:0]     grant;
  logic               can_accept;
  logic               accept;
  logic               grant_chain;
  logic [W-1:0]       a_sel, b_sel;
  logic               cin;
  logic [W-1:0]       add_sum;
  logic               add_cout;

  // While locked only the owner may win, even if it has no beat this cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (state_q == StIdle) begin
        eligible[i] = req_valid[i];
      end else begin
        eligible[i] = req_valid[i] && (owner_q == IdW'(i));
      end
    end
  end

  assign ptr_ext     = 3'(rr_ptr_q);
  assign pick        = rr_pick(eligible, NREQ, ptr_ext);
  assign grant_valid = pick[3];
  assign grant       = pick[IdW-1:0];

  logic unused_pick;
  assign unused_pick = ^pick;

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = grant_valid && can_accept;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    a_sel       = '0;
    b_sel       = '0;
    grant_chain = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == IdW'(i)) begin
        a_sel       = req_a[i*W +: W];
        b_sel       = req_b[i*W +: W];
        grant_chain = req_chain[i];
      end
    end
  end

  assign cin = (state_q == StLocked) ? carry_q : 1'b0;

  prefix_adder #(
    .W (W)
  ) u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;

    if (accept) begin
      carry_d     = add_cout;
      rr_ptr_d    = grant;
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_id_d    = grant;
      unique case (state_q)
        StIdle: begin
          if (grant_chain) begin
            state_d = StLocked;
            owner_d = grant;
          end
        end
        StLocked: begin
          if (!grant_chain) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= IdW'(NREQ - 1);
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_prefix_add_arbiter.sv
// Directed-vector bench for prefix_add_arbiter: single beat, wrap, round robin,
// two-limb chain with lock, backpressure, and asynchronous reset mid-chain.
module tb_prefix_add_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_chain;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [1:0]        rsp_id;

  int n_vec;
  int n_err;

  prefix_add_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic chain);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_chain[i]    = chain;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [7:0] s,
                           input logic c, input logic [1:0] id);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".sum"},   32'(rsp_sum),   32'(s));
    check({tag, ".cout"},  32'(rsp_cout),  32'(c));
    check({tag, ".id"},    32'(rsp_id),    32'(id));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_chain = '0;
    rsp_ready = 1'b1;

    #2;
    check_rsp("reset", 1'b0, 8'h00, 1'b0, 2'd0);
    check("reset.ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single beat from requester 0.
    set_req(0, 8'h7F, 8'h01, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("single.ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check_rsp("single", 1'b1, 8'h80, 1'b0, 2'd0);

    // Wrap-around from requester 3; also leaves rr_ptr at 3.
    set_req(3, 8'hFF, 8'hFF, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    check_rsp("wrap", 1'b1, 8'hFE, 1'b1, 2'd3);

    // Round robin with all four valid: ids 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'h10, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_rsp($sformatf("rr%0d", k), 1'b1, 8'(8'h10 + (k % 4)), 1'b0, 2'(k % 4));
    end
    req_valid = '0;
    tick();
    check("rr.drain", 32'(rsp_valid), 32'h0);

    // Two-limb chain from requester 1 with requester 2 competing.
    set_req(1, 8'hFF, 8'h01, 1'b1);
    set_req(2, 8'h05, 8'h06, 1'b0);
    req_valid = 4'b0110;
    #1;
    check("chain.ready0", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("chain.l0", 1'b1, 8'h00, 1'b1, 2'd1);
    req_valid = 4'b0100;
    #1;
    check("chain.locked", 32'(req_ready), 32'h0);
    tick();
    check("chain.gap", 32'(rsp_valid), 32'h0);
    set_req(1, 8'h00, 8'h00, 1'b0);
    req_valid = 4'b0110;
    #1;
    check("chain.ready1", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("chain.l1", 1'b1, 8'h01, 1'b0, 2'd1);
    req_valid = 4'b0100;
    #1;
    check("chain.release", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check_rsp("chain.req2", 1'b1, 8'h0B, 1'b0, 2'd2);

    // Backpressure: response held, no grants, then drain+accept together.
    rsp_ready = 1'b0;
    set_req(3, 8'h20, 8'h22, 1'b0);
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
      tick();
      check_rsp($sformatf("bp%0d", k), 1'b1, 8'h0B, 1'b0, 2'd2);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.accept", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    check_rsp("bp.reload", 1'b1, 8'h42, 1'b0, 2'd3);
    tick();

    // Reset while locked discards lock, carry and response.
    set_req(0, 8'hFF, 8'hFF, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check_rsp("rst.l0", 1'b1, 8'hFE, 1'b1, 2'd0);
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst.async", 32'(rsp_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    set_req(0, 8'h01, 8'h01, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("rst.ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check_rsp("rst.after", 1'b1, 8'h02, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
